mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles in WAIT before forced abort (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single system clock; all state on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 pN_req  input  1  (N=0 fetch, N=1 data) level request; addr/wdata/we/funct3 held stable until pN_ack.
REQ-005 pN_addr  input  32  byte address.
REQ-006 pN_wdata  input  32  store data.
REQ-007 pN_we  input  1  1=write, 0=read.
REQ-008 pN_funct3  input  3  access size/sign code, passed through unchanged.
REQ-009 pN_ack  output  1  one-cycle completion pulse.
REQ-010 pN_rdata  output  32  read data, valid when pN_ack=1.
REQ-011 pN_fault  output  1  access fault, valid when pN_ack=1.
REQ-012 mem_ce  output  1  active-low chip enable to the memory unit.
REQ-013 mem_addr/mem_datain/mem_funct3/mem_memwrite  output  32/32/3/1  registered payload of the granted port.
REQ-014 mem_dataout  input  32  memory read data.
REQ-015 mem_busy, mem_valid, mem_fault  input  1 each  memory status (busy, read-valid, load_access_fault).
REQ-016 grant  output  1  index of the port owning the current transaction.
REQ-017 arb_busy  output  1  high in every state except IDLE.
REQ-018 timeout  output  1  one-cycle pulse on watchdog abort.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE: if any pN_req is high, select a winner, latch its payload into mem_* registers, set grant, go to ISSUE; otherwise stay.
REQ-021 Arbitration: round-robin; with both requests high, the port not granted last wins; a single requester wins immediately.
REQ-022 ISSUE: drive mem_ce=0 for exactly one cycle, ignore the status inputs (the memory is still idle), go to WAIT.
REQ-023 WAIT: hold mem_ce=0; complete when mem_valid=1 OR mem_fault=1 OR mem_busy=0; on completion capture mem_dataout and mem_fault, then go to DONE.
REQ-024 DONE: mem_ce=1, pulse pN_ack for the granted port with the captured rdata/fault, update the round-robin pointer, go to IDLE.
REQ-025 Any pN_req seen in IDLE is a new request; minimum transaction length is 4 cycles (IDLE to IDLE).
REQ-026 mem_ce=1 in IDLE and DONE, so the memory unit returns to its idle state between transactions.
REQ-027 A request that drops before grant is ignored; requests arriving during ISSUE/WAIT/DONE wait for IDLE.
REQ-028 pN_rdata and pN_fault hold their last captured values between acks; the non-granted port's ack stays 0.

Reset
REQ-029 Assertion of reset, including mid-transaction, immediately forces: state=IDLE, mem_ce=1, mem_* payload=0, ack/fault/timeout=0, rdata=0, grant=0, round-robin pointer set so that port 1 wins the first tie.

Configuration
REQ-030 Macro MEM_ARB_TIMEOUT_EN defined: a counter runs in WAIT; on reaching TIMEOUT_CYCLES it goes to DONE with pN_fault=1, rdata=0, and timeout pulsed for that cycle.
REQ-031 Macro MEM_ARB_TIMEOUT_EN undefined: no counter; WAIT lasts indefinitely; timeout is tied to 0.

Structure
REQ-032 Shared package mem_arb_pkg: FSM state enum, port-index type, NUM_PORTS=2.
REQ-033 Sub-module rr_arbiter2 (two-request round-robin grant with last-grant pointer update) is instantiated once.

Verification
REQ-034 p0 read 0x000100, mem_valid after 5 WAIT cycles with dataout 0xDEADBEEF -> p0_ack for one cycle, p0_rdata=0xDEADBEEF, p0_fault=0.
REQ-035 p0 and p1 requests raised in the same cycle, repeated 4 times -> grants alternate 1,0,1,0.
REQ-036 p1 write 0x1000000 data 0xA5 -> mem_memwrite=1, mem_datain=0xA5, mem_busy falls -> p1_ack, then mem_ce=1 for one cycle.
REQ-037 p0 read 0x2000000, mem_fault=1 on first WAIT cycle -> p0_ack with p0_fault=1.
REQ-038 Reset asserted during WAIT -> mem_ce=1 and arb_busy=0 asynchronously, no ack emitted.
REQ-039 With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_busy stuck at 1 -> after 16 WAIT cycles, timeout=1 and p0_fault=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the two-port memory arbiter: the FSM state
//   encoding, the port index type and the port count.
package mem_arb_pkg;

   localparam int NUM_PORTS = 2;

   // One bit selects between port 0 (fetch) and port 1 (data).
   typedef logic port_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Two-request round-robin grant. The winner is combinational from the
//   current requests and the last-granted pointer; the pointer moves only
//   when update is pulsed.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   req[1:0]          request vector (bit N = port N)
//   update            load update_idx into the last-grant pointer
//   update_idx        index of the port just served
//   any               at least one request is present
//   winner            selected port index (meaningful when any=1)
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_PORTS-1:0] req,
   input  logic              update,
   input  port_idx_t         update_idx,
   output logic              any,
   output port_idx_t         winner
);

   port_idx_t last;

   // Reset pointer says port 0 was served last, so port 1 wins the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last <= 1'b0;
      end else if (update) begin
         last <= update_idx;
      end
   end

   always_comb begin
      any    = |req;
      winner = 1'b0;
      if (req == 2'b11) begin
         winner = ~last;
      end else if (req[1]) begin
         winner = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates a fetch port (p0) and a data port (p1) onto a single memory
//   unit. Each transaction walks IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   Handshake: a port raises pN_req with its payload held stable; the
//   arbiter answers with a single-cycle pN_ack carrying pN_rdata/pN_fault,
//   after which the port may drop or change its request.
// Configuration:
//   MEM_ARB_TIMEOUT_EN  when defined, WAIT is bounded by TIMEOUT_CYCLES and
//                       an expired wait completes with fault=1, rdata=0 and
//                       a timeout pulse; when undefined WAIT is unbounded
//                       and timeout is tied low.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   pN_req/addr/wdata/we/funct3   port N request and payload
//   pN_ack/rdata/fault            port N completion
//   mem_ce                        active-low chip enable (low in ISSUE/WAIT)
//   mem_addr/datain/funct3/memwrite  registered payload of granted port
//   mem_dataout/busy/valid/fault  memory status and read data
//   grant                         port owning the current transaction
//   arb_busy                      high outside IDLE
//   timeout                       watchdog abort pulse (in DONE)
//   fsm_state                     current FSM state for observation
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic        p0_we,
   input  logic [2:0]  p0_funct3,
   output logic        p0_ack,
   output logic [31:0] p0_rdata,
   output logic        p0_fault,
   input  logic        p1_req,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic        p1_we,
   input  logic [2:0]  p1_funct3,
   output logic        p1_ack,
   output logic [31:0] p1_rdata,
   output logic        p1_fault,
   output logic        mem_ce,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_datain,
   output logic [2:0]  mem_funct3,
   output logic        mem_memwrite,
   input  logic [31:0] mem_dataout,
   input  logic        mem_busy,
   input  logic        mem_valid,
   input  logic        mem_fault,
   output port_idx_t   grant,
   output logic        arb_busy,
   output logic        timeout,
   output arb_state_t  fsm_state
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   arb_state_t state, state_nxt;
   logic       rr_any;
   port_idx_t  rr_winner;
   logic       wait_done;
   logic       abort;

   rr_arbiter2 u_rr (
      .clk        (clk),
      .reset      (reset),
      .req        ({p1_req, p0_req}),
      .update     (state == ST_DONE),
      .update_idx (grant),
      .any        (rr_any),
      .winner     (rr_winner)
   );

   // Memory is done when it reports data, reports a fault, or simply goes idle.
   assign wait_done = mem_valid | mem_fault | ~mem_busy;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] wait_cnt;
   logic          timeout_q;

   // A genuine completion on the last allowed cycle wins over the abort.
   assign abort   = (state == ST_WAIT) && !wait_done &&
                    (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign timeout = timeout_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         wait_cnt  <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
         timeout_q <= abort;
      end
   end
`else
   assign abort   = 1'b0;
   assign timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (rr_any) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  if (wait_done || abort) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      mem_ce    = !((state == ST_ISSUE) || (state == ST_WAIT));
      arb_busy  = (state != ST_IDLE);
      p0_ack    = (state == ST_DONE) && (grant == 1'b0);
      p1_ack    = (state == ST_DONE) && (grant == 1'b1);
      fsm_state = state;
   end

   // Payload latch in IDLE, result capture at the end of WAIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant        <= 1'b0;
         mem_addr     <= '0;
         mem_datain   <= '0;
         mem_funct3   <= '0;
         mem_memwrite <= 1'b0;
         p0_rdata     <= '0;
         p0_fault     <= 1'b0;
         p1_rdata     <= '0;
         p1_fault     <= 1'b0;
      end else begin
         if (state == ST_IDLE && rr_any) begin
            grant        <= rr_winner;
            mem_addr     <= rr_winner ? p1_addr   : p0_addr;
            mem_datain   <= rr_winner ? p1_wdata  : p0_wdata;
            mem_funct3   <= rr_winner ? p1_funct3 : p0_funct3;
            mem_memwrite <= rr_winner ? p1_we     : p0_we;
         end
         if (state == ST_WAIT && (wait_done || abort)) begin
            if (grant == 1'b0) begin
               p0_rdata <= wait_done ? mem_dataout : 32'h0;
               p0_fault <= wait_done ? mem_fault   : 1'b1;
            end else begin
               p1_rdata <= wait_done ? mem_dataout : 32'h0;
               p1_fault <= wait_done ? mem_fault   : 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter: a table of single-port transactions
//   plus hand-written sequences for tie alternation, reset during WAIT and
//   the WAIT watchdog (MEM_ARB_TIMEOUT_EN selects which variant runs).
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
   logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
   logic [2:0]  p0_funct3 = 0, p1_funct3 = 0;
   logic        p0_ack, p0_fault, p1_ack, p1_fault;
   logic [31:0] p0_rdata, p1_rdata;
   logic        mem_ce, mem_memwrite;
   logic [31:0] mem_addr, mem_datain;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_dataout = 0;
   logic        mem_busy = 0, mem_valid = 0, mem_fault = 0;
   port_idx_t   grant;
   logic        arb_busy, timeout;
   arb_state_t  fsm_state;

   mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we),
      .p0_funct3(p0_funct3), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_fault(p0_fault),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
      .p1_funct3(p1_funct3), .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_fault(p1_fault),
      .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_datain(mem_datain),
      .mem_funct3(mem_funct3), .mem_memwrite(mem_memwrite),
      .mem_dataout(mem_dataout), .mem_busy(mem_busy), .mem_valid(mem_valid),
      .mem_fault(mem_fault), .grant(grant), .arb_busy(arb_busy),
      .timeout(timeout), .fsm_state(fsm_state)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] hold_rdata [2];
   logic        hold_fault [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic ack_of(input int p);
      return (p == 1) ? p1_ack : p0_ack;
   endfunction

   function automatic logic [31:0] rdata_of(input int p);
      return (p == 1) ? p1_rdata : p0_rdata;
   endfunction

   function automatic logic fault_of(input int p);
      return (p == 1) ? p1_fault : p0_fault;
   endfunction

   // ---------------- vector table ----------------
   // kind: 0 = mem_valid, 1 = mem_fault, 2 = mem_busy falls
   typedef struct {
      int          port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      int          wait_n;
      int          kind;
      logic        noise;
      logic [31:0] dout;
      logic [31:0] exp_rdata;
      logic        exp_fault;
   } vec_t;

   vec_t vecs [5];

   // ---------------- driver tasks ----------------
   task automatic set_req(input int p, input logic r, input vec_t v);
      if (p == 0) begin
         p0_req = r; p0_we = v.we; p0_addr = v.addr; p0_wdata = v.wdata; p0_funct3 = v.f3;
      end else begin
         p1_req = r; p1_we = v.we; p1_addr = v.addr; p1_wdata = v.wdata; p1_funct3 = v.f3;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      hold_rdata[0] = '0; hold_rdata[1] = '0;
      hold_fault[0] = 1'b0; hold_fault[1] = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int o;
      string tag;
      o = 1 - v.port;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      mem_busy = 1; mem_valid = 0; mem_fault = 0; mem_dataout = 32'hFFFF_FFFF;
      set_req(v.port, 1'b1, v);
      @(negedge clk);
      check({tag, "_issue_state"}, 32'(fsm_state), 32'(ST_ISSUE));
      check({tag, "_issue_ce"}, 32'(mem_ce), 32'd0);
      check({tag, "_grant"}, 32'(grant), 32'(v.port));
      check({tag, "_mem_addr"}, mem_addr, v.addr);
      check({tag, "_mem_datain"}, mem_datain, v.wdata);
      check({tag, "_mem_we"}, 32'(mem_memwrite), 32'(v.we));
      check({tag, "_mem_f3"}, 32'(mem_funct3), 32'(v.f3));
      exp_q.push_back(v.exp_rdata);
      if (v.noise) begin
         mem_valid = 1; mem_busy = 0;
      end
      @(negedge clk);
      mem_valid = 0; mem_busy = 1;
      check({tag, "_wait_state"}, 32'(fsm_state), 32'(ST_WAIT));
      for (int i = 0; i < v.wait_n; i++) begin
         check({tag, "_wait_ce"}, 32'(mem_ce), 32'd0);
         check({tag, "_wait_ack"}, 32'({p1_ack, p0_ack}), 32'd0);
         @(negedge clk);
      end
      mem_dataout = v.dout;
      case (v.kind)
         0: mem_valid = 1;
         1: mem_fault = 1;
         default: mem_busy = 0;
      endcase
      @(negedge clk);
      mem_valid = 0; mem_fault = 0; mem_busy = 0;
      check({tag, "_done_state"}, 32'(fsm_state), 32'(ST_DONE));
      check({tag, "_ack"}, 32'(ack_of(v.port)), 32'd1);
      check({tag, "_other_ack"}, 32'(ack_of(o)), 32'd0);
      check({tag, "_rdata"}, rdata_of(v.port), exp_q.pop_front());
      check({tag, "_fault"}, 32'(fault_of(v.port)), 32'(v.exp_fault));
      check({tag, "_other_rdata"}, rdata_of(o), hold_rdata[o]);
      check({tag, "_done_ce"}, 32'(mem_ce), 32'd1);
      check({tag, "_timeout"}, 32'(timeout), 32'd0);
      set_req(v.port, 1'b0, v);
      @(negedge clk);
      check({tag, "_idle_state"}, 32'(fsm_state), 32'(ST_IDLE));
      check({tag, "_idle_ack"}, 32'({p1_ack, p0_ack}), 32'd0);
      check({tag, "_idle_busy"}, 32'(arb_busy), 32'd0);
      check({tag, "_rdata_hold"}, rdata_of(v.port), v.exp_rdata);
      hold_rdata[v.port] = v.exp_rdata;
      hold_fault[v.port] = v.exp_fault;
   endtask

   // ---------------- test ----------------
   initial begin
      vec_t v;
      int w, l;
      //          port we addr           wdata          f3 wait kind noise dout           exp_rdata      fault
      vecs[0] = '{0, 0, 32'h0000_0100, 32'h0,         3'd2, 5, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{1, 1, 32'h0100_0000, 32'h0000_00A5, 3'd2, 3, 2, 0, 32'h0,         32'h0,         1'b0};
      vecs[2] = '{0, 0, 32'h0200_0000, 32'h0,         3'd0, 0, 1, 0, 32'h1234_5678, 32'h1234_5678, 1'b1};
      vecs[3] = '{1, 0, 32'h0000_0040, 32'h0,         3'd4, 1, 0, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
      vecs[4] = '{0, 1, 32'h0000_0080, 32'hCAFE_BABE, 3'd1, 0, 2, 1, 32'h0000_0055, 32'h0000_0055, 1'b0};

      // reset state
      reset = 1'b0;
      @(negedge clk);
      check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
      check("rst_ce", 32'(mem_ce), 32'd1);
      check("rst_busy", 32'(arb_busy), 32'd0);
      check("rst_payload", mem_addr | mem_datain | 32'(mem_funct3) | 32'(mem_memwrite), 32'd0);
      check("rst_acks", 32'({p1_ack, p0_ack, timeout, grant}), 32'd0);
      check("rst_rdata", p0_rdata | p1_rdata, 32'd0);
      check("rst_faults", 32'({p1_fault, p0_fault}), 32'd0);
      do_reset();

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // simultaneous requests after reset: grants 1,0,1,0
      do_reset();
      for (int k = 0; k < 4; k++) begin
         w = (k % 2 == 0) ? 1 : 0;
         l = 1 - w;
         @(negedge clk);
         p0_addr = 32'h10 + 32'(k); p1_addr = 32'h20 + 32'(k);
         p0_req = 1; p1_req = 1; mem_busy = 1;
         @(negedge clk);
         check($sformatf("tie%0d_grant", k), 32'(grant), 32'(w));
         check($sformatf("tie%0d_addr", k), mem_addr, (w == 1) ? 32'h20 + 32'(k) : 32'h10 + 32'(k));
         if (l == 0) p0_req = 0; else p1_req = 0;
         @(negedge clk);
         mem_valid = 1; mem_dataout = 32'h100 + 32'(k);
         @(negedge clk);
         mem_valid = 0; mem_busy = 0;
         check($sformatf("tie%0d_ack", k), 32'({p1_ack, p0_ack}), (w == 1) ? 32'd2 : 32'd1);
         check($sformatf("tie%0d_rdata", k), rdata_of(w), 32'h100 + 32'(k));
         p0_req = 0; p1_req = 0;
         @(negedge clk);
      end

      // reset asserted in the middle of WAIT
      @(negedge clk);
      p0_req = 1; p0_addr = 32'h300; p0_we = 0; mem_busy = 1;
      repeat (3) @(negedge clk);
      check("mid_wait_state", 32'(fsm_state), 32'(ST_WAIT));
      #2 reset = 1'b0;
      #1;
      check("async_rst_ce", 32'(mem_ce), 32'd1);
      check("async_rst_busy", 32'(arb_busy), 32'd0);
      check("async_rst_ack", 32'({p1_ack, p0_ack}), 32'd0);
      check("async_rst_addr", mem_addr, 32'd0);
      p0_req = 0; mem_busy = 0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_quiet", 32'({p1_ack, p0_ack, arb_busy}), 32'd0);
      end

      // stuck memory in WAIT
      v = '{0, 0, 32'h0000_0400, 32'h0, 3'd2, 0, 0, 0, 32'h0, 32'h0, 1'b0};
      @(negedge clk);
      mem_busy = 1; mem_dataout = 32'h7777_7777;
      set_req(0, 1'b1, v);
      @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("to_wait_state", 32'(fsm_state), 32'(ST_WAIT));
         check("to_no_pulse", 32'(timeout), 32'd0);
      end
      @(negedge clk);
      check("to_pulse", 32'(timeout), 32'd1);
      check("to_ack", 32'(p0_ack), 32'd1);
      check("to_fault", 32'(p0_fault), 32'd1);
      check("to_rdata", p0_rdata, 32'd0);
      set_req(0, 1'b0, v);
      mem_busy = 0;
      @(negedge clk);
      check("to_pulse_end", 32'(timeout), 32'd0);
`else
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("stuck_wait_state", 32'(fsm_state), 32'(ST_WAIT));
      end
      mem_busy = 0;
      @(negedge clk);
      check("stuck_ack", 32'(p0_ack), 32'd1);
      check("stuck_timeout", 32'(timeout), 32'd0);
      check("stuck_rdata", p0_rdata, 32'h7777_7777);
      set_req(0, 1'b0, v);
      @(negedge clk);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
